// File: rtl/cpu_mult_pkg.sv
// Shared definitions for the pipelined CPU multiplier: op encodings and pipeline limits.
package cpu_mult_pkg;

    localparam int unsigned MIN_LATENCY = 2;
    localparam int unsigned MAX_LATENCY = 4;
    localparam int unsigned OP_W        = 2;

    typedef enum logic [OP_W-1:0] {
        MUL_OP_LO = 2'b00,
        MUL_OP_SS = 2'b01,
        MUL_OP_SU = 2'b10,
        MUL_OP_UU = 2'b11
    } mul_op_e;

    // Operand a is treated as signed for the two mixed/signed high-half ops.
    function automatic logic op_a_signed(mul_op_e op);
        return (op == MUL_OP_SS) || (op == MUL_OP_SU);
    endfunction

    function automatic logic op_b_signed(mul_op_e op);
        return op == MUL_OP_SS;
    endfunction

endpackage

// File: rtl/cpu_mult_lane.sv
// One registered unsigned LANE_W x LANE_W partial product, intended for a hard multiplier block.
module cpu_mult_lane #(
    parameter int unsigned LANE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [LANE_W-1:0]     a,
    input  logic [LANE_W-1:0]     b,
    output logic [2*LANE_W-1:0]   p
);

    localparam int unsigned P_W = 2 * LANE_W;

    always_ff @(posedge clk) begin
        if (reset) begin
            p <= '0;
        end else if (en) begin
            p <= P_W'(a) * P_W'(b);
        end
    end

endmodule

// File: rtl/cpu_mult_unit.sv
// Pipelined DATA_W x DATA_W multiplier: four lane products, sign correction, half select
// and an optional output delay line, all frozen by en.
module cpu_mult_unit
    import cpu_mult_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              in_valid,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic              busy
);

    localparam int unsigned LANE_W = DATA_W / 2;
    localparam int unsigned PROD_W = 2 * DATA_W;

    if ((DATA_W < 4) || ((DATA_W % 2) != 0)) begin : g_bad_data_w
        $error("cpu_mult_unit: DATA_W must be even and >= 4");
    end
    if ((LATENCY < MIN_LATENCY) || (LATENCY > MAX_LATENCY)) begin : g_bad_latency
        $error("cpu_mult_unit: LATENCY must be in 2..4");
    end

    logic [DATA_W-1:0] p_ll, p_lh, p_hl, p_hh;

    cpu_mult_lane #(.LANE_W(LANE_W)) u_lane_ll (
        .clk(clk), .reset(reset), .en(en),
        .a(in_a[LANE_W-1:0]), .b(in_b[LANE_W-1:0]), .p(p_ll)
    );
    cpu_mult_lane #(.LANE_W(LANE_W)) u_lane_lh (
        .clk(clk), .reset(reset), .en(en),
        .a(in_a[LANE_W-1:0]), .b(in_b[DATA_W-1:LANE_W]), .p(p_lh)
    );
    cpu_mult_lane #(.LANE_W(LANE_W)) u_lane_hl (
        .clk(clk), .reset(reset), .en(en),
        .a(in_a[DATA_W-1:LANE_W]), .b(in_b[LANE_W-1:0]), .p(p_hl)
    );
    cpu_mult_lane #(.LANE_W(LANE_W)) u_lane_hh (
        .clk(clk), .reset(reset), .en(en),
        .a(in_a[DATA_W-1:LANE_W]), .b(in_b[DATA_W-1:LANE_W]), .p(p_hh)
    );

    // Stage 1 side-band: op, sign-correction flags and the operands they subtract.
    logic              s1_valid;
    mul_op_e           s1_op;
    logic              s1_ca;
    logic              s1_cb;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_op    <= MUL_OP_LO;
            s1_ca    <= 1'b0;
            s1_cb    <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_op    <= mul_op_e'(in_op);
            s1_ca    <= in_a[DATA_W-1] & op_a_signed(mul_op_e'(in_op));
            s1_cb    <= in_b[DATA_W-1] & op_b_signed(mul_op_e'(in_op));
            s1_a     <= in_a;
            s1_b     <= in_b;
        end
    end

    // Stage 2: unsigned sum, then a negative operand's MSB weight is removed as x<<DATA_W.
    logic [PROD_W-1:0] sum_u;
    logic [PROD_W-1:0] corr_a;
    logic [PROD_W-1:0] corr_b;
    logic [PROD_W-1:0] prod;
    logic [DATA_W-1:0] res_sel;

    always_comb begin
        sum_u   = PROD_W'(p_ll)
                + (PROD_W'(p_lh) << LANE_W)
                + (PROD_W'(p_hl) << LANE_W)
                + (PROD_W'(p_hh) << DATA_W);
        corr_a  = s1_ca ? {s1_b, {DATA_W{1'b0}}} : '0;
        corr_b  = s1_cb ? {s1_a, {DATA_W{1'b0}}} : '0;
        prod    = sum_u - corr_a - corr_b;
        res_sel = (s1_op == MUL_OP_LO) ? prod[DATA_W-1:0] : prod[PROD_W-1:DATA_W];
    end

    // Index 1 is the stage-2 output register; higher indices form the extra delay line.
    logic [LATENCY-1:1]             v_q;
    logic [LATENCY-1:1][DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= '0;
            r_q <= '0;
        end else if (en) begin
            v_q[1] <= s1_valid;
            r_q[1] <= res_sel;
            for (int unsigned i = 2; i < LATENCY; i++) begin
                v_q[i] <= v_q[i-1];
                r_q[i] <= r_q[i-1];
            end
        end
    end

    assign out_valid  = v_q[LATENCY-1];
    assign out_result = r_q[LATENCY-1];
    assign busy       = s1_valid | (|v_q);

endmodule

// File: tb/tb_cpu_mult_unit.sv
// Scoreboard bench for cpu_mult_unit: three instances (32b/L2, 32b/L4, 16b/L2) share one stimulus stream.
module tb_cpu_mult_unit;

    localparam int unsigned N_DUT = 3;
    localparam int unsigned LAT [N_DUT] = '{2, 4, 2};
    localparam int unsigned WID [N_DUT] = '{32, 32, 16};

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        in_valid;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;

    logic [N_DUT-1:0] ov;
    logic [N_DUT-1:0] bz;
    logic [31:0]      r0;
    logic [31:0]      r1;
    logic [15:0]      r2;

    always #5 clk = ~clk;

    cpu_mult_unit #(.DATA_W(32), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .out_valid(ov[0]), .out_result(r0), .busy(bz[0])
    );
    cpu_mult_unit #(.DATA_W(32), .LATENCY(4)) u_dut_l4 (
        .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .out_valid(ov[1]), .out_result(r1), .busy(bz[1])
    );
    cpu_mult_unit #(.DATA_W(16), .LATENCY(2)) u_dut_w16 (
        .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_op(in_op),
        .in_a(in_a[15:0]), .in_b(in_b[15:0]), .out_valid(ov[2]), .out_result(r2), .busy(bz[2])
    );

    exp_t        sb [N_DUT][$];
    logic        exp_v [N_DUT];
    logic [31:0] exp_r [N_DUT];
    bit          exp_known [N_DUT];
    int          ecnt;
    int          vectors;
    int          miscompares;

    // Reference: sign/zero-extend to 64 bits, multiply modulo 2^64, pick the half.
    function automatic logic [31:0] ref_mul(logic [1:0] op, logic [31:0] a, logic [31:0] b,
                                            int unsigned w);
        logic [63:0] mask, ax, bx, p;
        mask = (64'd1 << w) - 64'd1;
        ax   = {32'd0, a} & mask;
        bx   = {32'd0, b} & mask;
        if ((op == 2'b01 || op == 2'b10) && ax[w-1]) ax = ax | ~mask;
        if (op == 2'b01 && bx[w-1]) bx = bx | ~mask;
        p = ax * bx;
        if (op == 2'b00) return 32'(p & mask);
        return 32'((p >> w) & mask);
    endfunction

    function automatic logic [31:0] res_of(int k);
        case (k)
            0:       return r0;
            1:       return r1;
            default: return {16'd0, r2};
        endcase
    endfunction

    task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s dut%0d cycle%0d observed=%h expected=%h", tag, k, ecnt, obs, expv);
        end
    endtask

    // One clock: drive inputs, take the edge, update the scoreboard, check all instances.
    task automatic step(bit rst, bit e, bit v, logic [1:0] op, logic [31:0] a, logic [31:0] b);
        reset    = rst;
        en       = e;
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < N_DUT; k++) begin
                sb[k].delete();
                exp_v[k]     = 1'b0;
                exp_r[k]     = '0;
                exp_known[k] = 1'b1;
            end
        end else if (e) begin
            ecnt++;
            for (int k = 0; k < N_DUT; k++) begin
                if (v) sb[k].push_back('{ref_mul(op, a, b, WID[k]), ecnt + int'(LAT[k]) - 1});
                if (sb[k].size() > 0 && sb[k][0].due == ecnt) begin
                    exp_v[k]     = 1'b1;
                    exp_r[k]     = sb[k][0].res;
                    exp_known[k] = 1'b1;
                    void'(sb[k].pop_front());
                end else begin
                    exp_v[k]     = 1'b0;
                    exp_known[k] = 1'b0;
                end
            end
        end
        #1;
        for (int k = 0; k < N_DUT; k++) begin
            chk("out_valid", k, 32'(ov[k]), 32'(exp_v[k]));
            if (exp_known[k]) chk("out_result", k, res_of(k), exp_r[k]);
            chk("busy", k, 32'(bz[k]), 32'((sb[k].size() > 0) || exp_v[k]));
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
    endtask

    initial begin
        ecnt        = 0;
        vectors     = 0;
        miscompares = 0;

        step(1'b1, 1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);

        // Low half of all-ones squared.
        step(1'b0, 1'b1, 1'b1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(4);

        // High-half modes back-to-back.
        step(1'b0, 1'b1, 1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, 1'b1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, 1'b1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, 1'b1, 2'b01, 32'h8000_0000, 32'h8000_0000);
        step(1'b0, 1'b1, 1'b1, 2'b11, 32'h8000_0000, 32'h8000_0000);
        step(1'b0, 1'b1, 1'b1, 2'b10, 32'h8000_0000, 32'h8000_0000);
        idle(5);

        // Stall with one operation in flight.
        step(1'b0, 1'b1, 1'b1, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
        step(1'b0, 1'b0, 1'b1, 2'b00, 32'hDEAD_BEEF, 32'h0000_0003);
        step(1'b0, 1'b0, 1'b0, 2'b01, 32'h0000_0001, 32'h0000_0001);
        step(1'b0, 1'b0, 1'b1, 2'b10, 32'h7777_7777, 32'h5555_5555);
        idle(5);

        // Reset with operations in flight, enabled and stalled.
        step(1'b0, 1'b1, 1'b1, 2'b00, 32'h0000_0007, 32'h0000_0009);
        step(1'b0, 1'b1, 1'b1, 2'b11, 32'hABCD_EF01, 32'h2345_6789);
        step(1'b1, 1'b1, 1'b1, 2'b01, 32'h1111_1111, 32'h2222_2222);
        idle(5);
        step(1'b0, 1'b1, 1'b1, 2'b01, 32'hF000_0001, 32'h0000_0010);
        step(1'b0, 1'b1, 1'b1, 2'b10, 32'h8000_0001, 32'hFFFF_0000);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        idle(5);

        // Bubble pattern 1,0,1.
        step(1'b0, 1'b1, 1'b1, 2'b00, 32'h0001_0003, 32'h0002_0005);
        step(1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_0000, 32'h0000_0000);
        step(1'b0, 1'b1, 1'b1, 2'b01, 32'hFFFF_FFFE, 32'h0000_0003);
        idle(5);

        // Narrow-width corner (the 16-bit instance sees the low halves).
        step(1'b0, 1'b1, 1'b1, 2'b10, 32'h0000_8000, 32'h0000_0002);
        step(1'b0, 1'b1, 1'b1, 2'b00, 32'h0000_8000, 32'h0000_0002);
        idle(5);

        // Random operands, ops, bubbles and stalls.
        for (int i = 0; i < 80; i++) begin
            step(1'b0, $urandom_range(0, 5) != 0, $urandom_range(0, 3) != 0,
                 2'($urandom_range(0, 3)), $urandom, $urandom);
        end
        idle(8);

        for (int k = 0; k < N_DUT; k++) chk("drain", k, 32'(sb[k].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_mult_unit.md
Name: cpu_mult_unit

Overview:
Parametrised, pipelined integer multiplier for the CPU execute/memory stages. It extends the three-partial-product cell to a full DATA_W x DATA_W product. The block supports signed, unsigned and mixed operands and selects the low or high result half. It carries a valid tag, honours a pipeline enable (stall), and returns a final DATA_W result rather than raw partial products.

Parameters:
DATA_W, 32, operand and result width; must be even and >= 4.
LANE_W, DATA_W/2, partial-product lane width; derived, not overridable.
LATENCY, 2, cycles from accepted input to out_valid; legal range 2..4.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
en  in  1  pipeline enable; 0 freezes every stage, including out_*.
in_valid  in  1  operands valid; sampled only when en=1.
in_op  in  2  00 MUL (low half), 01 MULXSS (high, signed x signed), 10 MULXSU (high, signed a x unsigned b), 11 MULXUU (high, unsigned x unsigned).
in_a  in  DATA_W  operand a.
in_b  in  DATA_W  operand b.
out_valid  out  1  result valid.
out_result  out  DATA_W  selected product half.
busy  out  1  OR of the valid bits in all stages.

Behaviour:
- Reset: every stage valid bit, out_valid, out_result and busy go to 0 on the first edge with reset=1. Reset has priority over en. Reset mid-operation discards all in-flight operations, with no partial output.
- Capture: an operation is accepted on an edge with en=1 and in_valid=1. The block has no backpressure; the caller stalls via en.
- en=0: all pipeline registers hold, out_valid and out_result keep their values, and in_* are ignored.
- Stage 1, at edge N of an accepted input:
  - Register four unsigned LANE_W x LANE_W products: pLL=aL*bL, pLH=aL*bH, pHL=aH*bL, pHH=aH*bH.
  - Register the op and two correction flags:
    - ca = a[MSB] & (op==01 | op==10)
    - cb = b[MSB] & (op==01)
  - Register the b and a values needed for correction.
- Stage 2:
  - Unsigned 2*DATA_W sum: U = pLL + (pLH<<LANE_W) + (pHL<<LANE_W) + (pHH<<DATA_W).
  - Signed correction, modulo 2^(2*DATA_W): P = U - (ca ? b<<DATA_W : 0) - (cb ? a<<DATA_W : 0).
  - Result select: op==00 gives P[DATA_W-1:0]; otherwise P[2*DATA_W-1:DATA_W].
  - The MUL low half equals U's low half; no correction is needed for op 00.
- Output registers: out_result and out_valid are registered at the end of stage 2. For LATENCY 3 and 4, insert LATENCY-2 further delay registers, all gated by en.
- Latency: out_valid=1 exactly LATENCY enabled edges after acceptance. Cycles with en=0 do not count.
- Throughput: one operation per enabled cycle, fully pipelined. Back-to-back inputs produce back-to-back outputs in order.
- Bubble: an enabled edge with in_valid=0 propagates a bubble. out_valid falls to 0 when the bubble reaches the output; out_result is then don't-care but stable.
- Overflow: arithmetic wraps; no flags are produced.
- busy is combinational from the stage valid bits.

Decomposition:
- Shared package cpu_mult_pkg:
  - op encodings MUL_OP_LO, MUL_OP_SS, MUL_OP_SU, MUL_OP_UU
  - the 2-bit op typedef
  - localparam MIN_LATENCY=2
- Sub-module cpu_mult_lane: one registered LANE_W x LANE_W unsigned multiplier with en and synchronous reset, instantiated four times. It maps to dedicated multiplier blocks.
- Correction, summation, select and delay line live in the top module.

Test Plan:
- Low half: DATA_W=32, LATENCY=2, op 00, a=b=0xFFFFFFFF -> out_result=0x00000001, out_valid exactly 2 edges after acceptance.
- High-half modes: a=b=0xFFFFFFFF with ops 11/01/10 issued back-to-back -> 0xFFFFFFFE, 0x00000000, 0xFFFFFFFF on consecutive cycles. Then a=b=0x80000000 with ops 01/11/10 -> 0x40000000, 0x40000000, 0xC0000000.
- Stall: accept a=0x12345678, b=0x9ABCDEF0, op 11, then hold en=0 for 3 cycles -> out_valid stays 0 and registers frozen. After en returns, 0x0B00EA4E appears on the 2nd enabled edge.
- Reset: reset=1 while two operations are in flight -> next cycle out_valid=0, busy=0, out_result=0; no stale result appears afterwards. reset=1 with en=0 still clears.
- Bubble/latency sweep: LATENCY=4, interleave in_valid 1,0,1 -> out_valid pattern 1,0,1 starting 4 edges later. Randomised signed/unsigned operands are checked against a 64-bit reference model.
- Width generality: DATA_W=16, a=0x8000, b=0x0002, op 10 -> 0xFFFF; op 00 -> 0x0000.
